// File: rtl/bus_arbiter_np_pkg.sv
// Shared definitions for the N-master bus arbiter: arbitration modes, FSM states, limits.
package bus_pkg;

    localparam int ARB_FIXED   = 0;
    localparam int ARB_RR      = 1;
    localparam int MAX_MASTERS = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/bus_arbiter_np_if.sv
// Arbiter-facing bundle of the serial system bus: requests and split control in, grants out.
interface bus_arbiter_np_if #(
    parameter int NUM_MASTERS = 4,
    parameter int ID_W        = $clog2(NUM_MASTERS)
);
    logic [NUM_MASTERS-1:0] breq;
    logic                   split_req;
    logic                   split_resume;
    logic [ID_W-1:0]        resume_id;
    logic [NUM_MASTERS-1:0] bgrant;
    logic [NUM_MASTERS-1:0] msplit;
    logic [ID_W-1:0]        owner;
    logic                   bus_busy;
    logic                   split_grant;

    // slave: the arbiter's view; master: the requesters' and slaves' view
    modport slave (
        input  breq, split_req, split_resume, resume_id,
        output bgrant, msplit, owner, bus_busy, split_grant
    );

    modport master (
        output breq, split_req, split_resume, resume_id,
        input  bgrant, msplit, owner, bus_busy, split_grant
    );
endinterface

// File: rtl/bus_arbiter_np_arb_pick.sv
// Rotating-start priority encoder: first set request at or after i_start, wrapping at N.
module arb_pick #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    i_req,
    input  logic [ID_W-1:0] i_start,
    output logic            o_found,
    output logic [ID_W-1:0] o_index
);

    // Scan from the farthest offset down so the nearest hit is the last one written.
    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[(int'(i_start) + k) % N]) begin
                o_found = 1'b1;
                o_index = ID_W'((int'(i_start) + k) % N);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_np.sv
// N-master bus arbiter with fixed-priority or round-robin selection and split/resume support.
module bus_arbiter_np
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ARB_MODE    = ARB_FIXED,
    parameter int ID_W        = $clog2(NUM_MASTERS)
) (
    input  logic             clk,
    input  logic             rst,
    bus_arbiter_np_if.slave  bus
);

    arb_state_t             r_state,       w_state_nxt;
    logic [NUM_MASTERS-1:0] r_bgrant,      w_bgrant_nxt;
    logic [NUM_MASTERS-1:0] r_msplit,      w_msplit_nxt;
    logic [NUM_MASTERS-1:0] r_resume_pend, w_pend_nxt;
    logic [ID_W-1:0]        r_owner,       w_owner_nxt;
    logic [ID_W-1:0]        r_last_owner,  w_last_nxt;
    logic                   r_split_grant, w_split_grant_nxt;
    logic                   r_bus_busy;

    logic [NUM_MASTERS-1:0] w_elig;
    logic [NUM_MASTERS-1:0] w_pend_elig;
    logic [ID_W-1:0]        w_rr_start;
    logic [ID_W-1:0]        w_pick_start;
    logic                   w_pend_found;
    logic                   w_elig_found;
    logic [ID_W-1:0]        w_pend_idx;
    logic [ID_W-1:0]        w_elig_idx;
    logic [ID_W-1:0]        w_winner;
    logic                   w_resume_ok;

    assign w_elig       = bus.breq & ~r_msplit;
    assign w_pend_elig  = r_resume_pend & w_elig;
    assign w_rr_start   = (r_last_owner == ID_W'(NUM_MASTERS - 1)) ? '0 : r_last_owner + 1'b1;
    assign w_pick_start = (ARB_MODE == ARB_RR) ? w_rr_start : '0;
    assign w_winner     = w_pend_found ? w_pend_idx : w_elig_idx;
    // resume_id may address a non-existent master when NUM_MASTERS is not a power of two
    assign w_resume_ok  = bus.split_resume && (int'(bus.resume_id) < NUM_MASTERS)
                          && r_msplit[bus.resume_id];

    arb_pick #(.N(NUM_MASTERS), .ID_W(ID_W)) u_pick_pend (
        .i_req   (w_pend_elig),
        .i_start ('0),
        .o_found (w_pend_found),
        .o_index (w_pend_idx)
    );

    arb_pick #(.N(NUM_MASTERS), .ID_W(ID_W)) u_pick_elig (
        .i_req   (w_elig),
        .i_start (w_pick_start),
        .o_found (w_elig_found),
        .o_index (w_elig_idx)
    );

    always_comb begin
        w_state_nxt       = r_state;
        w_bgrant_nxt      = r_bgrant;
        w_msplit_nxt      = r_msplit;
        w_pend_nxt        = r_resume_pend;
        w_owner_nxt       = r_owner;
        w_last_nxt        = r_last_owner;
        w_split_grant_nxt = 1'b0;

        // Resume acts on stored flags and can coincide with a split of the current owner.
        if (w_resume_ok) begin
            w_msplit_nxt[bus.resume_id] = 1'b0;
            w_pend_nxt[bus.resume_id]   = 1'b1;
        end

        case (r_state)
            IDLE: begin
                if (w_elig_found) begin
                    w_state_nxt           = OWNED;
                    w_bgrant_nxt          = '0;
                    w_bgrant_nxt[w_winner] = 1'b1;
                    w_owner_nxt           = w_winner;
                    w_last_nxt            = w_winner;
                    w_pend_nxt[w_winner]  = 1'b0;
                    w_split_grant_nxt     = w_pend_found;
                end
            end
            OWNED: begin
                if (bus.split_req) begin
                    w_msplit_nxt[r_owner] = 1'b1;
                    w_bgrant_nxt          = '0;
                    w_state_nxt           = IDLE;
                end else if (!bus.breq[r_owner]) begin
                    w_bgrant_nxt = '0;
                    w_state_nxt  = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_bgrant      <= '0;
            r_msplit      <= '0;
            r_resume_pend <= '0;
            r_owner       <= '0;
            r_last_owner  <= ID_W'(NUM_MASTERS - 1);
            r_split_grant <= 1'b0;
            r_bus_busy    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_bgrant      <= w_bgrant_nxt;
            r_msplit      <= w_msplit_nxt;
            r_resume_pend <= w_pend_nxt;
            r_owner       <= w_owner_nxt;
            r_last_owner  <= w_last_nxt;
            r_split_grant <= w_split_grant_nxt;
            r_bus_busy    <= |w_bgrant_nxt;
        end
    end

    assign bus.bgrant      = r_bgrant;
    assign bus.msplit      = r_msplit;
    assign bus.owner       = r_owner;
    assign bus.bus_busy    = r_bus_busy;
    assign bus.split_grant = r_split_grant;

endmodule

// File: tb/tb_bus_arbiter_np.sv
// Bench for bus_arbiter_np: fixed-priority and round-robin instances driven in lockstep.
module tb_bus_arbiter_np;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] breq;
    logic       split_req;
    logic       split_resume;
    logic [1:0] resume_id;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bus_arbiter_np_if #(.NUM_MASTERS(N)) if_fp ();
    bus_arbiter_np_if #(.NUM_MASTERS(N)) if_rr ();

    assign if_fp.breq         = breq;
    assign if_fp.split_req    = split_req;
    assign if_fp.split_resume = split_resume;
    assign if_fp.resume_id    = resume_id;
    assign if_rr.breq         = breq;
    assign if_rr.split_req    = split_req;
    assign if_rr.split_resume = split_resume;
    assign if_rr.resume_id    = resume_id;

    bus_arbiter_np #(.NUM_MASTERS(N), .ARB_MODE(0)) dut_fp (.clk(clk), .rst(rst), .bus(if_fp));
    bus_arbiter_np #(.NUM_MASTERS(N), .ARB_MODE(1)) dut_rr (.clk(clk), .rst(rst), .bus(if_rr));

    // Reference model state, index 0 = fixed priority, 1 = round-robin
    logic [3:0] m_split [2];
    logic [3:0] m_pend  [2];
    int         m_owner [2];
    int         m_last  [2];
    bit         m_busy  [2];
    bit         m_sg    [2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        breq         = '0;
        split_req    = 1'b0;
        split_resume = 1'b0;
        resume_id    = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Next-cycle behaviour from the arbitration rules, applied to the current inputs.
    task automatic model_step(input int m);
        logic [3:0] elig;
        int         win;
        int         c;
        bit         rp;
        if (rst) begin
            m_split[m] = '0; m_pend[m] = '0; m_owner[m] = 0;
            m_last[m]  = N - 1; m_busy[m] = 1'b0; m_sg[m] = 1'b0;
            return;
        end
        elig = breq & ~m_split[m];
        win  = -1;
        rp   = 1'b0;
        if (!m_busy[m]) begin
            for (int i = 0; i < N; i++)
                if (win < 0 && m_pend[m][i] && elig[i]) begin win = i; rp = 1'b1; end
            for (int k = 1; k <= N; k++) begin
                c = (m == 0) ? k - 1 : (m_last[m] + k) % N;
                if (win < 0 && elig[c]) win = c;
            end
        end
        if (split_resume && m_split[m][resume_id]) begin
            m_split[m][resume_id] = 1'b0;
            m_pend[m][resume_id]  = 1'b1;
        end
        m_sg[m] = 1'b0;
        if (m_busy[m]) begin
            if (split_req) begin
                m_split[m][m_owner[m]] = 1'b1;
                m_busy[m] = 1'b0;
            end else if (!breq[m_owner[m]]) begin
                m_busy[m] = 1'b0;
            end
        end else if (win >= 0) begin
            m_busy[m]       = 1'b1;
            m_owner[m]      = win;
            m_last[m]       = win;
            m_pend[m][win]  = 1'b0;
            m_sg[m]         = rp;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        breq = 4'b1111;
        rst  = 1'b1;
        tick();
        total++;
        if ({if_fp.bgrant, if_fp.msplit, if_fp.owner, if_fp.bus_busy, if_fp.split_grant} !== 12'h000) begin
            bad++;
            $display("FAIL reset_fp got=%b/%b/%0d/%b/%b want all zero", if_fp.bgrant, if_fp.msplit,
                     if_fp.owner, if_fp.bus_busy, if_fp.split_grant);
        end
        total++;
        if ({if_rr.bgrant, if_rr.msplit, if_rr.owner, if_rr.bus_busy, if_rr.split_grant} !== 12'h000) begin
            bad++;
            $display("FAIL reset_rr got=%b/%b/%0d/%b/%b want all zero", if_rr.bgrant, if_rr.msplit,
                     if_rr.owner, if_rr.bus_busy, if_rr.split_grant);
        end
        rst = 1'b0;
    endtask

    task automatic test_fixed();
        do_reset();
        breq = 4'b1010;
        tick();
        total++;
        if (if_fp.bgrant !== 4'b0010 || if_fp.owner !== 2'd1 || if_fp.bus_busy !== 1'b1) begin
            bad++;
            $display("FAIL fixed_first got=%b owner=%0d busy=%b want=0010 owner=1 busy=1",
                     if_fp.bgrant, if_fp.owner, if_fp.bus_busy);
        end
        breq = 4'b1000;
        tick();
        total++;
        if (if_fp.bgrant !== 4'b0000 || if_fp.bus_busy !== 1'b0 || if_fp.owner !== 2'd1) begin
            bad++;
            $display("FAIL fixed_dead got=%b busy=%b owner=%0d want=0000 busy=0 owner=1",
                     if_fp.bgrant, if_fp.bus_busy, if_fp.owner);
        end
        tick();
        total++;
        if (if_fp.bgrant !== 4'b1000 || if_fp.owner !== 2'd3) begin
            bad++;
            $display("FAIL fixed_second got=%b owner=%0d want=1000 owner=3", if_fp.bgrant, if_fp.owner);
        end
    endtask

    task automatic test_round_robin();
        int g;
        do_reset();
        breq = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            g = n % N;
            tick();
            total++;
            if (if_rr.bgrant !== 4'(1 << g) || if_rr.owner !== 2'(g)) begin
                bad++;
                $display("FAIL rr_grant%0d got=%b want=%b", n, if_rr.bgrant, 4'(1 << g));
            end
            tick();
            tick();
            breq[g] = 1'b0;
            tick();
            total++;
            if (if_rr.bgrant !== 4'b0000) begin
                bad++;
                $display("FAIL rr_dead%0d got=%b want=0000", n, if_rr.bgrant);
            end
            breq = 4'b1111;
        end
    endtask

    task automatic test_split();
        do_reset();
        breq = 4'b0100;
        tick();
        breq      = 4'b0101;
        split_req = 1'b1;
        tick();
        split_req = 1'b0;
        total++;
        if (if_fp.msplit !== 4'b0100 || if_fp.bgrant !== 4'b0000 || if_fp.bus_busy !== 1'b0) begin
            bad++;
            $display("FAIL split_flag msplit=%b bgrant=%b busy=%b want=0100/0000/0",
                     if_fp.msplit, if_fp.bgrant, if_fp.bus_busy);
        end
        tick();
        total++;
        if (if_fp.bgrant !== 4'b0001 || if_fp.split_grant !== 1'b0) begin
            bad++;
            $display("FAIL split_next got=%b sg=%b want=0001 sg=0", if_fp.bgrant, if_fp.split_grant);
        end
    endtask

    task automatic test_resume_priority();
        do_reset();
        breq = 4'b1000;
        tick();
        split_req = 1'b1;
        tick();
        split_req    = 1'b0;
        split_resume = 1'b1;
        resume_id    = 2'd3;
        tick();
        split_resume = 1'b0;
        total++;
        if (if_fp.msplit !== 4'b0000 || if_fp.bgrant !== 4'b0000) begin
            bad++;
            $display("FAIL resume_clear msplit=%b bgrant=%b want=0000/0000", if_fp.msplit, if_fp.bgrant);
        end
        breq = 4'b1001;
        tick();
        total++;
        if (if_fp.bgrant !== 4'b1000 || if_fp.split_grant !== 1'b1) begin
            bad++;
            $display("FAIL resume_grant got=%b sg=%b want=1000 sg=1", if_fp.bgrant, if_fp.split_grant);
        end
        tick();
        total++;
        if (if_fp.split_grant !== 1'b0 || if_fp.bgrant !== 4'b1000) begin
            bad++;
            $display("FAIL resume_pulse got=%b sg=%b want=1000 sg=0", if_fp.bgrant, if_fp.split_grant);
        end
        breq = 4'b0001;
        tick();
        tick();
        total++;
        if (if_fp.bgrant !== 4'b0001 || if_fp.split_grant !== 1'b0) begin
            bad++;
            $display("FAIL resume_follow got=%b sg=%b want=0001 sg=0", if_fp.bgrant, if_fp.split_grant);
        end
    endtask

    task automatic test_corners();
        do_reset();
        split_req = 1'b1;
        tick();
        split_req = 1'b0;
        total++;
        if (if_fp.msplit !== 4'b0000 || if_fp.bgrant !== 4'b0000) begin
            bad++;
            $display("FAIL split_idle msplit=%b bgrant=%b want=0000/0000", if_fp.msplit, if_fp.bgrant);
        end
        split_resume = 1'b1;
        resume_id    = 2'd1;
        tick();
        split_resume = 1'b0;
        breq         = 4'b0010;
        tick();
        total++;
        if (if_fp.bgrant !== 4'b0010 || if_fp.split_grant !== 1'b0 || if_fp.msplit !== 4'b0000) begin
            bad++;
            $display("FAIL stray_resume got=%b sg=%b msplit=%b want=0010 sg=0 msplit=0000",
                     if_fp.bgrant, if_fp.split_grant, if_fp.msplit);
        end
        breq      = 4'b0000;
        split_req = 1'b1;
        tick();
        split_req = 1'b0;
        total++;
        if (if_fp.msplit !== 4'b0010 || if_fp.bgrant !== 4'b0000) begin
            bad++;
            $display("FAIL split_release msplit=%b bgrant=%b want=0010/0000", if_fp.msplit, if_fp.bgrant);
        end
        breq = 4'b0010;
        tick();
        tick();
        total++;
        if (if_fp.bgrant !== 4'b0000 || if_fp.bus_busy !== 1'b0) begin
            bad++;
            $display("FAIL all_split got=%b busy=%b want=0000 busy=0", if_fp.bgrant, if_fp.bus_busy);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        breq = 4'b0001;
        tick();
        breq      = 4'b0011;
        split_req = 1'b1;
        tick();
        split_req = 1'b0;
        tick();
        split_req = 1'b1;
        tick();
        split_req = 1'b0;
        breq      = 4'b0111;
        tick();
        total++;
        if (if_fp.msplit !== 4'b0011 || if_fp.bgrant !== 4'b0100) begin
            bad++;
            $display("FAIL mid_setup msplit=%b bgrant=%b want=0011/0100", if_fp.msplit, if_fp.bgrant);
        end
        rst = 1'b1;
        tick();
        total++;
        if ({if_fp.bgrant, if_fp.msplit, if_fp.owner, if_fp.bus_busy, if_fp.split_grant} !== 12'h000) begin
            bad++;
            $display("FAIL mid_reset got=%b/%b/%0d/%b want all zero", if_fp.bgrant, if_fp.msplit,
                     if_fp.owner, if_fp.bus_busy);
        end
        rst  = 1'b0;
        breq = 4'b0001;
        tick();
        total++;
        if (if_fp.bgrant !== 4'b0001 || if_fp.bus_busy !== 1'b1) begin
            bad++;
            $display("FAIL post_reset got=%b busy=%b want=0001 busy=1", if_fp.bgrant, if_fp.bus_busy);
        end
    endtask

    task automatic test_random();
        logic [11:0] exp_v;
        logic [11:0] act_v;
        idle_inputs();
        rst = 1'b1;
        model_step(0);
        model_step(1);
        tick();
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(3) == 0) breq[i] = ~breq[i];
            split_req    = ($urandom_range(7) == 0);
            split_resume = ($urandom_range(5) == 0);
            resume_id    = 2'($urandom_range(3));
            rst          = ($urandom_range(99) == 0);
            model_step(0);
            model_step(1);
            tick();
            exp_v = {m_busy[0] ? 4'(1 << m_owner[0]) : 4'b0, m_split[0], 2'(m_owner[0]), m_busy[0], m_sg[0]};
            act_v = {if_fp.bgrant, if_fp.msplit, if_fp.owner, if_fp.bus_busy, if_fp.split_grant};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL rand_fp cyc=%0d got=%b want=%b (grant|msplit|owner|busy|sg)", cyc, act_v, exp_v);
            end
            exp_v = {m_busy[1] ? 4'(1 << m_owner[1]) : 4'b0, m_split[1], 2'(m_owner[1]), m_busy[1], m_sg[1]};
            act_v = {if_rr.bgrant, if_rr.msplit, if_rr.owner, if_rr.bus_busy, if_rr.split_grant};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL rand_rr cyc=%0d got=%b want=%b (grant|msplit|owner|busy|sg)", cyc, act_v, exp_v);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_fixed();
        test_round_robin();
        test_split();
        test_resume_priority();
        test_corners();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
